uart_rx_deframer: RTL



---
 rtl/uart_rx_deframer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop synchroniser, mid-bit sampling, even parity,
// stop/break checking, one-cycle push strobe and registered RTS.
module uart_rx_deframer #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 2,
  parameter int OVERSAMPLE = 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Rx_Data,
  output logic                 Rx_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 RTS,
  output logic                 Rx_Busy
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_SMP  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_TOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  typedef struct packed {
    logic frame;
    logic parity;
    logic brk;
  } rx_err_t;

  state_t               state, state_nxt;
  logic [1:0]           sync_q;
  logic                 rs, rs_d, armed, tick;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, stop_and, stop_or;
  logic                 go_start, last_stop, stop_and_nxt, stop_or_nxt;
  rx_err_t              err_nxt;

  // rs_d is the bit value each sample point looks at; one extra stage lets the
  // start bit be sampled on the cycle after IDLE sees the falling edge.
  assign rs           = sync_q[1];
  assign tick         = (cnt == CNT_SMP);
  assign go_start     = (state == IDLE) && armed && !rs;
  assign last_stop    = (state == STOP) && tick && (stop_idx == 1'b0);
  assign stop_and_nxt = stop_and & rs_d;
  assign stop_or_nxt  = stop_or | rs_d;
  assign Rx_Busy      = (state != IDLE);

  // Break (whole frame low) masks the parity and frame flags.
  always_comb begin
    err_nxt = '0;
    if (shreg == '0 && !par_bit && !stop_or_nxt) begin
      err_nxt.brk = 1'b1;
    end else begin
      err_nxt.parity = (^shreg) != par_bit;
      err_nxt.frame  = !stop_and_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (go_start) state_nxt = START;
      START:  if (tick) state_nxt = rs_d ? IDLE : DATA;
      DATA:   if (tick && bit_idx == '0) state_nxt = PARITY;
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (last_stop) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync_q   <= 2'b11;
      rs_d     <= 1'b1;
      armed    <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      stop_and <= 1'b0;
      stop_or  <= 1'b0;
      Rx_Data  <= '0;
      Rx_Valid <= 1'b0;
      Rx_Error <= '0;
      RTS      <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], Rx};
      rs_d     <= rs;
      RTS      <= !FIFO_Full;
      Rx_Valid <= 1'b0;

      // A start needs rs seen high since the last start or a low-ending frame.
      if (rs)
        armed <= 1'b1;
      else if (go_start || (state == DONE && !stop_and))
        armed <= 1'b0;

      if (state == IDLE)         cnt <= '0;
      else if (cnt == CNT_LAST)  cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      unique case (state)
        START: if (tick && !rs_d) bit_idx <= IDX_TOP;
        DATA: if (tick) begin
          shreg   <= DATA_BITS'({shreg, rs_d});
          bit_idx <= bit_idx - 1'b1;
        end
        PARITY: if (tick) begin
          par_bit  <= rs_d;
          stop_idx <= STOP_TOP;
          stop_and <= 1'b1;
          stop_or  <= 1'b0;
        end
        STOP: if (tick) begin
          stop_and <= stop_and_nxt;
          stop_or  <= stop_or_nxt;
          stop_idx <= stop_idx - 1'b1;
          // Strobe lands in the DONE cycle.
          if (last_stop) begin
            Rx_Valid <= 1'b1;
            Rx_Data  <= shreg;
            Rx_Error <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
